rv32i_imem_ctrl: RTL
====================

Name: rv32i_imem_ctrl

Overview:
Controller and arbiter for the single-port instruction memory. It sits between the fetch stage, a program loader stream and the synchronous instruction SRAM.
- After reset it runs a boot sequence: the loader fills the memory, then the controller releases the core.
- At run time it shares the port between fetch reads and loader patch writes, with anti-starvation for the loader.
- Loads program images in hardware, which testbench back-door loading cannot do.

Parameters:
- INSTR_MEM_WIDTH, 10, word-index bits; depth = 2**INSTR_MEM_WIDTH words.
- LD_MAX_WAIT, 4, consecutive RUN cycles a valid loader write may be blocked before it takes priority over fetch (range 1..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ld_valid  in  1  loader write valid.
- ld_ready  out  1  loader write accepted this cycle when ld_valid&&ld_ready.
- ld_addr  in  32  loader byte address.
- ld_data  in  32  loader write word.
- ld_last  in  1  marks final boot word.
- ld_err  out  1  sticky: a loader write was dropped (misaligned or out of range).
- if_req  in  1  fetch read request.
- if_addr  in  32  fetch byte address (PC).
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  read response valid.
- if_rdata  out  32  instruction word.
- if_err  out  1  response is an access fault; qualified by if_rvalid.
- core_run  out  1  core may leave reset and fetch.
- mem_en  out  1  SRAM access enable.
- mem_we  out  1  SRAM write enable.
- mem_idx  out  INSTR_MEM_WIDTH  SRAM word index.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en&&!mem_we.

Behaviour:
- Address check:
  - Legal = addr[1:0]==0 and addr[31:INSTR_MEM_WIDTH+2]==0.
  - Word index = addr[INSTR_MEM_WIDTH+1:2].
- States: ST_LOAD (reset state), ST_RUN.
- Reset (rst_n low at a clock edge):
  - State goes to ST_LOAD; wait counter and ld_err cleared.
  - core_run=0, if_rvalid=0, if_err=0, if_rdata=0, if_gnt=0, ld_ready=0, mem_en=0, mem_we=0.
  - Any in-flight read response is discarded.
  - The same applies mid-operation.
- ST_LOAD:
  - ld_ready=1 (once rst_n is high), if_gnt=0, core_run=0.
  - Accepted legal write: mem_en=1, mem_we=1, mem_idx from ld_addr, mem_wdata=ld_data, all in the same cycle.
  - Accepted illegal write: no SRAM access; ld_err set next cycle.
  - Accepted beat with ld_last=1 (legal or not): next state ST_RUN; core_run=1 from the next cycle.
- ST_RUN:
  - core_run=1.
  - ld_last is ignored; the block never returns to ST_LOAD except via reset.
- Arbitration in ST_RUN, all combinational within the cycle:
  - Default priority is fetch: if_gnt=if_req, ld_ready=!if_req.
  - Wait counter increments on each cycle with ld_valid && !ld_ready, saturating at LD_MAX_WAIT.
  - When the counter == LD_MAX_WAIT, the loader has priority: ld_ready=1, if_gnt=0.
  - Counter clears on any accepted loader beat, and whenever ld_valid=0.
- Fetch read timing:
  - On grant of a legal address: mem_en=1, mem_we=0.
  - Next cycle: if_rvalid=1, if_rdata=mem_rdata, if_err=0. Fixed 1-cycle latency.
  - One grant is allowed per cycle (fully pipelined back-to-back).
- Fetch read of an illegal address:
  - Granted, but no SRAM access.
  - Next cycle: if_rvalid=1, if_err=1, if_rdata=32'h0000_0013 (NOP).
- if_rvalid=0 in every cycle not following a grant.
- if_rdata holds its last value when if_rvalid=0.
- mem_en=0 when there is no grant.
- Simultaneous loader write and fetch to the same index: only one is granted per cycle. Data written in cycle N is readable by a fetch granted in cycle N+1 or later.

Decomposition:
- Shared package/defs header (rv32i_defs.vh) holds:
  - INSTR_MEM_WIDTH and INSTR_MEM_DEPTH, already present.
  - New IMEM_ST_LOAD / IMEM_ST_RUN encodings.
  - RV32I_NOP = 32'h0000_0013.
- Address-legality check as a shared function in the header, reused by the data-memory side.
- No sub-module inside the controller. The synchronous SRAM (rv32i_imem_sram, 1-cycle read) is a sibling instantiated at the top level.

Test Plan:
- Boot load: write words 0x00500093, 0x00A00113 at addresses 0x0, 0x4 (ld_last on the 2nd) -> two SRAM writes at idx 0 and 1; core_run rises the cycle after the last beat; then fetch 0x4 -> if_rvalid one cycle after grant with 0x00A00113.
- Illegal accesses:
  - Loader addr 0x2 in ST_LOAD -> no mem_we; ld_err=1 and sticky.
  - Fetch 0x0000_1000 (W=10) -> if_rvalid, if_err=1, if_rdata=0x00000013.
- Back-to-back fetch at PC 0,4,8,12 with if_req held high -> if_gnt every cycle; four consecutive if_rvalid beats in order, 1-cycle latency.
- Starvation, LD_MAX_WAIT=4: if_req constantly high, ld_valid high in ST_RUN -> ld_ready=0 for 4 cycles, ld_ready=1 and if_gnt=0 on the 5th, then fetch resumes and the counter resets.
- Reset mid-run: assert rst_n=0 the cycle after a fetch grant -> next edge if_rvalid=0, core_run=0, state ST_LOAD, ld_err cleared; ld_ready=1 once rst_n returns high.

Source files
------------

// File: rtl/rv32i_imem_ctrl_pkg.sv
// Shared instruction-memory definitions: geometry, FSM encodings, NOP constant
// and the word-address legality check that the data-memory side reuses too.
package rv32i_imem_ctrl_pkg;

  localparam int INSTR_MEM_WIDTH = 10;
  localparam int INSTR_MEM_DEPTH = 1 << INSTR_MEM_WIDTH;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  typedef enum logic {
    IMEM_ST_LOAD = 1'b0,
    IMEM_ST_RUN  = 1'b1
  } imem_state_e;

  // Word aligned and inside the 2**width word window starting at address 0.
  function automatic logic addr_legal(input logic [31:0] addr, input int width);
    logic [31:0] hi;
    hi = addr >> (width + 2);
    return (addr[1:0] == 2'b00) && (hi == 32'd0);
  endfunction

endpackage

// File: rtl/rv32i_imem_ctrl_if.sv
// Bundle of loader, fetch and SRAM-side signals around the instruction memory
// controller; slave is the controller's view, master the surrounding system's.
interface rv32i_imem_ctrl_if #(
  parameter int INSTR_MEM_WIDTH = 10
);

  logic                       ld_valid;
  logic                       ld_ready;
  logic [31:0]                ld_addr;
  logic [31:0]                ld_data;
  logic                       ld_last;
  logic                       ld_err;

  logic                       if_req;
  logic [31:0]                if_addr;
  logic                       if_gnt;
  logic                       if_rvalid;
  logic [31:0]                if_rdata;
  logic                       if_err;

  logic                       core_run;

  logic                       mem_en;
  logic                       mem_we;
  logic [INSTR_MEM_WIDTH-1:0] mem_idx;
  logic [31:0]                mem_wdata;
  logic [31:0]                mem_rdata;

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_last,
    input  if_req, if_addr,
    input  mem_rdata,
    output ld_ready, ld_err,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output core_run,
    output mem_en, mem_we, mem_idx, mem_wdata
  );

  modport master (
    output ld_valid, ld_addr, ld_data, ld_last,
    output if_req, if_addr,
    output mem_rdata,
    input  ld_ready, ld_err,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  core_run,
    input  mem_en, mem_we, mem_idx, mem_wdata
  );

endinterface

// File: rtl/rv32i_imem_ctrl.sv
// Instruction memory controller: boots the SRAM from the loader stream, then
// arbitrates the single port between fetch reads and loader patch writes.
module rv32i_imem_ctrl #(
  parameter int INSTR_MEM_WIDTH = rv32i_imem_ctrl_pkg::INSTR_MEM_WIDTH,
  parameter int LD_MAX_WAIT     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  rv32i_imem_ctrl_if.slave    bus
);

  import rv32i_imem_ctrl_pkg::*;

  localparam logic [3:0] MAX_WAIT = 4'(LD_MAX_WAIT);

  imem_state_e                state_q, state_d;
  logic [3:0]                 wait_q, wait_d;
  logic                       ld_err_q;
  logic                       rvalid_q;
  logic                       rerr_q;
  logic [31:0]                rdata_q;

  logic                       ld_legal, if_legal;
  logic [INSTR_MEM_WIDTH-1:0] ld_idx, if_idx;
  logic                       ld_prio;
  logic                       ld_ready_c, if_gnt_c;
  logic                       ld_acc;
  logic                       mem_en_c, mem_we_c;
  logic [INSTR_MEM_WIDTH-1:0] mem_idx_c;
  logic [31:0]                mem_wdata_c;
  logic [31:0]                rdata_now;

  assign ld_legal = addr_legal(bus.ld_addr, INSTR_MEM_WIDTH);
  assign if_legal = addr_legal(bus.if_addr, INSTR_MEM_WIDTH);
  assign ld_idx   = bus.ld_addr[INSTR_MEM_WIDTH+1:2];
  assign if_idx   = bus.if_addr[INSTR_MEM_WIDTH+1:2];
  assign ld_prio  = (wait_q == MAX_WAIT);
  assign ld_acc   = bus.ld_valid && ld_ready_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IMEM_ST_LOAD;
      wait_q   <= '0;
      ld_err_q <= 1'b0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      if (ld_acc && !ld_legal) begin
        ld_err_q <= 1'b1;
      end
      rvalid_q <= if_gnt_c;
      if (if_gnt_c) begin
        rerr_q <= !if_legal;
      end
      if (rvalid_q) begin
        rdata_q <= rdata_now;
      end
    end
  end

  // A blocked loader beat ages the wait counter; dropping valid or getting in clears it.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      IMEM_ST_LOAD: begin
        if (ld_acc && bus.ld_last) begin
          state_d = IMEM_ST_RUN;
        end
      end
      IMEM_ST_RUN: begin
        if (bus.ld_valid && !ld_ready_c) begin
          wait_d = (wait_q == MAX_WAIT) ? wait_q : wait_q + 4'd1;
        end
      end
      default: state_d = IMEM_ST_LOAD;
    endcase
  end

  always_comb begin
    ld_ready_c  = 1'b0;
    if_gnt_c    = 1'b0;
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_idx_c   = if_idx;
    mem_wdata_c = bus.ld_data;
    if (rst_n) begin
      if (state_q == IMEM_ST_LOAD) begin
        ld_ready_c = 1'b1;
      end else if (ld_prio) begin
        ld_ready_c = 1'b1;
      end else begin
        if_gnt_c   = bus.if_req;
        ld_ready_c = !bus.if_req;
      end
    end
    // Illegal addresses are still handshaken but never reach the SRAM.
    if (bus.ld_valid && ld_ready_c && ld_legal) begin
      mem_en_c  = 1'b1;
      mem_we_c  = 1'b1;
      mem_idx_c = ld_idx;
    end else if (if_gnt_c && if_legal) begin
      mem_en_c  = 1'b1;
    end
  end

  assign rdata_now     = rerr_q ? RV32I_NOP : bus.mem_rdata;

  assign bus.ld_ready  = ld_ready_c;
  assign bus.ld_err    = ld_err_q;
  assign bus.if_gnt    = if_gnt_c;
  assign bus.if_rvalid = rvalid_q;
  assign bus.if_err    = rvalid_q && rerr_q;
  assign bus.if_rdata  = rvalid_q ? rdata_now : rdata_q;
  assign bus.core_run  = (state_q == IMEM_ST_RUN);
  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_idx   = mem_idx_c;
  assign bus.mem_wdata = mem_wdata_c;

endmodule
